// File: rtl/quad_step_decoder.sv
// Quadrature A/B front end: 2-FF sync, per-phase run-length glitch filter, Gray-step decode.
// Define QDEC_ERR_CNT_EN to add the saturating 8-bit err_count output.
module quad_step_decoder #(
  parameter int FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_a,
  input  logic       in_b,
  input  logic       err_clr,
  output logic       enable,
  output logic       up_down,
`ifdef QDEC_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  output logic       error
);

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state, state_nxt;
  logic [1:0]      init_cnt;
  logic            init_done;
  logic [1:0]      sync_p0, sync_p1;
  logic [1:0]      filt_p2, prev_p2;
  logic [1:0][3:0] run_cnt;
  logic [1:0]      chg;
  logic            step_vld, illegal, dir;

`ifdef QDEC_ERR_CNT_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
`endif

  // Stage p0/p1: two-flop synchroniser, pairs kept as {a,b}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {in_a, in_b};
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_cnt <= init_cnt + 2'd1;
    end
  end

  // Stage p2: run-length filter; prev_p2 trails filt_p2 by one cycle so any change is seen once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_p2 <= '0;
      prev_p2 <= '0;
      run_cnt <= '0;
    end else if (state == INIT) begin
      run_cnt <= '0;
      if (init_done) begin
        filt_p2 <= sync_p1;
        prev_p2 <= sync_p1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == filt_p2[i]) begin
          run_cnt[i] <= '0;
        end else if (run_cnt[i] == FILT_MAX) begin
          filt_p2[i] <= sync_p1[i];
          run_cnt[i] <= '0;
        end else begin
          run_cnt[i] <= run_cnt[i] + 4'd1;
        end
      end
      prev_p2 <= filt_p2;
    end
  end

  assign chg = filt_p2 ^ prev_p2;

  always_comb begin
    state_nxt = state;
    init_done = 1'b0;
    step_vld  = 1'b0;
    illegal   = 1'b0;
    dir       = up_down;
    case (state)
      INIT: begin
        if (init_cnt == 2'd2) begin
          state_nxt = RUN;
          init_done = 1'b1;
        end
      end
      RUN: begin
        if (chg == 2'b11) begin
          illegal = 1'b1;
        end else if (chg != 2'b00) begin
          step_vld = 1'b1;
          // forward order 00->01->11->10 is exactly the case old_a != new_b
          dir      = prev_p2[1] ^ filt_p2[0];
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  // Stage p3: registered outputs; direction updates on the same edge as the pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable  <= 1'b0;
      up_down <= 1'b1;
      error   <= 1'b0;
    end else begin
      enable <= step_vld;
      if (step_vld) up_down <= dir;
      if (illegal)      error <= 1'b1;
      else if (err_clr) error <= 1'b0;
    end
  end

`ifdef QDEC_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err_count <= '0;
    else if (err_clr) err_count <= {7'd0, illegal};
    else if (illegal) err_count <= sat_inc(err_count);
  end
`endif

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder (FILT_LEN=3); expected pulses are queued with due cycle.
module tb_quad_step_decoder;

  localparam int FILT_LEN = 3;
  localparam int LAT      = FILT_LEN + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_a = 1'b0, in_b = 1'b0, err_clr = 1'b0;
  logic enable, up_down, error;
`ifdef QDEC_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  quad_step_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_a      (in_a),
    .in_b      (in_b),
    .err_clr   (err_clr),
    .enable    (enable),
    .up_down   (up_down),
`ifdef QDEC_ERR_CNT_EN
    .err_count (err_count),
`endif
    .error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   t;
    logic dir;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic       exp_ud = 1'b1;
  logic       exp_en;
  logic [1:0] mdl = 2'b00;
  logic       mdl_err = 1'b0;
  int         mdl_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic fwd(input logic [1:0] p, input logic [1:0] n);
    case ({p, n})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Every cycle: enable must match the scoreboard, up_down must hold the last step's direction
  always @(negedge clk) begin
    exp_en = (sb.size() > 0) && (sb[0].t == cyc);
    check("enable", {31'd0, enable}, {31'd0, exp_en});
    if (exp_en) begin
      exp_ud = sb[0].dir;
      void'(sb.pop_front());
    end
    check("up_down", {31'd0, up_down}, {31'd0, exp_ud});
  end

  task automatic chk_err(input string tag);
    check(tag, {31'd0, error}, {31'd0, mdl_err});
`ifdef QDEC_ERR_CNT_EN
    check({tag, "_cnt"}, {24'd0, err_count}, 32'(mdl_cnt));
`endif
  endtask

  // Call just after a negedge; clr_off selects the hold cycle in which err_clr is high (-1: none)
  task automatic step(input logic [1:0] ab, input int hold, input int clr_off);
    logic [1:0] chg;
    logic       ill;
    exp_t       e;
    chg = ab ^ mdl;
    ill = (chg == 2'b11);
    if (chg == 2'b01 || chg == 2'b10) begin
      e.t   = cyc + LAT;
      e.dir = fwd(mdl, ab);
      sb.push_back(e);
    end
    {in_a, in_b} = ab;
    mdl = ab;
    for (int i = 0; i < hold; i++) begin
      err_clr = (i == clr_off);
      @(negedge clk);
    end
    err_clr = 1'b0;
    if (clr_off >= 0) begin
      mdl_err = ill;
      mdl_cnt = ill ? 1 : 0;
    end else if (ill) begin
      mdl_err = 1'b1;
      if (mdl_cnt < 255) mdl_cnt++;
    end
  endtask

  // Asserts reset between edges and checks the outputs drop without waiting for a clock
  task automatic do_reset(input logic [1:0] ab);
    {in_a, in_b} = ab;
    @(posedge clk);
    #2 reset = 1'b0;
    sb.delete();
    exp_ud = 1'b1;
    #1;
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_up_down", {31'd0, up_down}, 32'd1);
    check("rst_error", {31'd0, error}, 32'd0);
`ifdef QDEC_ERR_CNT_EN
    check("rst_err_count", {24'd0, err_count}, 32'd0);
`endif
    repeat (4) @(negedge clk);
    reset   = 1'b1;
    mdl     = ab;
    mdl_err = 1'b0;
    mdl_cnt = 0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #1;
    // Idle after reset at 00
    do_reset(2'b00);
    chk_err("idle_error");

    // Forward then reverse full cycles
    step(2'b01, 10, -1);
    step(2'b11, 10, -1);
    step(2'b10, 10, -1);
    step(2'b00, 10, -1);
    chk_err("fwd_error");
    step(2'b10, 10, -1);
    step(2'b11, 10, -1);
    step(2'b01, 10, -1);
    step(2'b00, 10, -1);
    chk_err("rev_error");

    // Two-cycle glitch on A is absorbed; a held change still steps
    in_a = 1'b1;
    repeat (2) @(negedge clk);
    in_a = 1'b0;
    repeat (10) @(negedge clk);
    chk_err("glitch_error");
    step(2'b10, 10, -1);
    step(2'b00, 10, -1);

    // Illegal jump, sticky error, clear, then clear colliding with a new illegal jump
    step(2'b11, 10, -1);
    chk_err("illegal_set");
    repeat (5) @(negedge clk);
    chk_err("illegal_sticky");
    step(2'b11, 8, 0);
    chk_err("err_clear");
    step(2'b00, 10, 5);
    chk_err("set_wins");

    // Leave up_down=0 and error=1, then reset mid-operation with pins at 11
    step(2'b10, 10, -1);
    do_reset(2'b11);
    chk_err("init11_error");
    step(2'b01, 10, -1);
    step(2'b11, 10, -1);
    chk_err("post_reset_error");

`ifdef QDEC_ERR_CNT_EN
    for (int i = 0; i < 300; i++) step(mdl ^ 2'b11, 7, -1);
    chk_err("count_sat");
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
